pipe_stall_ctrl: RTL and testbench
==================================

// Module: pipe_stall_ctrl
// PURPOSE
//  Central pipeline controller for the 5-stage core. Drives the per-stage stall
//  vector consumed by pc_reg and every inter-stage register (if_id .. mem_wb).
//  Sequences multi-cycle EX operations (madd/msub, div) with a cycle counter.
//  Raises a one-cycle flush with a redirect PC on exceptions and ERET.
// PARAMETERS
//  EXC_ENTRY   32'h0000_0020  redirect PC for every exception except ERET
//  ERET_CODE   32'h0000_000e  excepttype value that selects cp0_epc as redirect
//  CNT_W       6              width of multi-cycle counter / mc_cycles
// PORTS
//  clk            in   1      rising-edge clock; the only clock
//  rst            in   1      synchronous, active-high reset (`RstEnable == 1'b1)
//  stallreq_id    in   1      ID hazard (load-use), hold PC/IF/ID
//  stallreq_ex    in   1      EX single-cycle hold request
//  stallreq_mem   in   1      MEM port busy, hold PC..MEM
//  mc_start       in   1      EX begins a multi-cycle op this cycle
//  mc_cycles      in   CNT_W  extra EX cycles required by the op (0 = none)
//  excepttype     in   32     MEM-stage exception code, 0 = no exception
//  cp0_epc        in   32     EPC from CP0, used for ERET
//  stall          out  6      [0]PC [1]IF [2]ID [3]EX [4]MEM [5]WB; 1 = hold
//  flush          out  1      clear all pipeline registers this edge
//  new_pc         out  32     redirect target, valid when flush=1
//  mc_busy        out  1      multi-cycle sequence in progress
//  mc_done        out  1      one-cycle pulse: EX result valid, stall released
// BEHAVIOUR
//  - States: IDLE, MC. State/counter registered; outputs combinational from
//    state, counter and inputs (same-cycle effect on stage registers).
//  - Reset (rst=1 at clk edge): state<=IDLE, cnt<=0. While rst=1 all outputs
//    forced 0 (stall=6'b0, flush=0, new_pc=32'h0, mc_busy=0, mc_done=0).
//  - Priority per cycle: exception > mem > multi-cycle/ex > id.
//  - Exception (excepttype!=0), any state: flush=1, stall=6'b000000,
//    new_pc = (excepttype==ERET_CODE) ? cp0_epc : EXC_ENTRY; next state IDLE,
//    cnt<=0, mc_done=0 (MC op aborted; mc_start same cycle ignored).
//  - stallreq_mem (no exc): stall=6'b011111; state/cnt frozen (no countdown).
//  - IDLE, mc_start=1, mc_cycles=N>0: stall=6'b001111, cnt<=N-1, ->MC.
//  - IDLE, mc_start=1, mc_cycles=0: mc_done=1 same cycle, no stall, stay IDLE.
//  - MC, cnt!=0: stall=6'b001111, mc_busy=1, cnt<=cnt-1.
//  - MC, cnt==0: mc_done=1, mc_busy=1, ->IDLE; stall from ex/id requests only.
//    Total EX occupancy for N: N+1 cycles; N cycles with stall[3]=1.
//  - mc_start while in MC: ignored (protocol error; assertion in bench).
//  - IDLE otherwise: stallreq_ex -> 6'b001111; else stallreq_id -> 6'b000111;
//    else 6'b000000. flush=0, new_pc=0 whenever no exception.
//  - stall is always a contiguous run of 1s from bit0; stall[5] never set.
//  - rst asserted mid-MC: next cycle IDLE, cnt=0, no mc_done pulse.
// STRUCTURE
//  - defines.v gains: `StallBus 5:0, `STALL_NONE/ID/EX/MEM encodings,
//    `ExcEntry, `ExcEret, `CntBus; state encodings localparam in-module.
//  - One sub-module natural: mc_counter (load/decrement/freeze, zero flag).
//    Priority/decoding logic stays flat in pipe_stall_ctrl.
// TESTING
//  1 rst=1 for 3 cycles with all requests high -> all outputs 0; after release
//    idle inputs -> stall=000000.
//  2 stallreq_id=1 -> stall=000111; add stallreq_ex=1 -> 001111; add
//    stallreq_mem=1 -> 011111.
//  3 mc_start, mc_cycles=3 -> stall=001111 for 3 cycles, mc_done on 4th cycle
//    with stall=000000, then IDLE; mc_cycles=0 -> mc_done same cycle, no stall.
//  4 mc_cycles=5, stallreq_mem=1 for 2 cycles mid-sequence -> stall=011111,
//    countdown frozen, mc_done 2 cycles late (cycle 8).
//  5 excepttype=1 in MC cycle 2 -> flush=1, new_pc=0x20, stall=0, no mc_done;
//    excepttype=0xe, cp0_epc=0x8000_0100 -> new_pc=0x8000_0100.
//  6 rst=1 during MC -> next cycle mc_busy=0, no mc_done ever for that op.

Source files
------------

// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared constants and types for the pipeline stall controller.
// Stall vectors are ordered [0]PC [1]IF [2]ID [3]EX [4]MEM [5]WB, 1 = hold.
package pipe_stall_ctrl_pkg;

    localparam int          CNT_W_DEF     = 6;
    localparam logic [31:0] EXC_ENTRY_DEF = 32'h0000_0020;
    localparam logic [31:0] ERET_CODE_DEF = 32'h0000_000e;

    localparam int STALL_W = 6;
    typedef logic [STALL_W-1:0] stall_bus_t;

    // Each encoding holds the requesting stage and everything upstream of it.
    localparam stall_bus_t STALL_NONE = 6'b000000;
    localparam stall_bus_t STALL_ID   = 6'b000111;
    localparam stall_bus_t STALL_EX   = 6'b001111;
    localparam stall_bus_t STALL_MEM  = 6'b011111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MC   = 1'b1
    } mc_state_e;

    // Stall contributed by the single-cycle EX and ID hold requests alone.
    function automatic stall_bus_t req_stall(input logic ex_req, input logic id_req);
        stall_bus_t s;
        if (ex_req) begin
            s = STALL_EX;
        end else if (id_req) begin
            s = STALL_ID;
        end else begin
            s = STALL_NONE;
        end
        return s;
    endfunction

endpackage

// File: rtl/pipe_stall_ctrl_mc_counter.sv
// Multi-cycle EX countdown counter: clear, load, decrement or hold.
// Clear wins over load, load wins over decrement; decrement saturates at zero.
module pipe_stall_ctrl_mc_counter
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             zero
);

    // Counter register; holds its value whenever no control is asserted.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central pipeline controller for the 5-stage core: per-stage stall vector,
// multi-cycle EX sequencing, and exception / ERET flush with redirect PC.
// Outputs are combinational so they act on the stage registers this cycle.
//
// Handshake: mc_start is a single-cycle request from EX, honoured only in
// IDLE with no exception and no MEM stall; mc_done pulses for one cycle on
// the cycle the EX result is valid and the EX hold is released.
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_ENTRY = EXC_ENTRY_DEF,
    parameter logic [31:0] ERET_CODE = ERET_CODE_DEF,
    parameter int          CNT_W     = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_id,
    input  logic             stallreq_ex,
    input  logic             stallreq_mem,
    input  logic             mc_start,
    input  logic [CNT_W-1:0] mc_cycles,
    input  logic [31:0]      excepttype,
    input  logic [31:0]      cp0_epc,
    output logic [5:0]       stall,
    output logic             flush,
    output logic [31:0]      new_pc,
    output logic             mc_busy,
    output logic             mc_done
);

    // FSM state is kept as a named signal so checkers can bind to it.
    mc_state_e        state;
    mc_state_e        state_nx;

    logic             exc_hit;
    logic             mc_req;
    logic             cnt_clr;
    logic             cnt_load;
    logic             cnt_dec;
    logic [CNT_W-1:0] cnt;
    logic             cnt_zero;
    logic [CNT_W-1:0] cnt_load_val;

    assign exc_hit      = (excepttype != 32'h0);
    assign mc_req       = mc_start && (mc_cycles != '0);
    // First cycle of the op is the IDLE start cycle, so load N-1.
    assign cnt_load_val = mc_cycles - CNT_W'(1);

    pipe_stall_ctrl_mc_counter #(
        .CNT_W (CNT_W)
    ) u_mc_counter (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and counter control: exception aborts, MEM stall freezes.
    always_comb begin
        state_nx = state;
        cnt_clr  = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        if (exc_hit) begin
            state_nx = ST_IDLE;
            cnt_clr  = 1'b1;
        end else if (!stallreq_mem) begin
            case (state)
                ST_IDLE: begin
                    if (mc_req) begin
                        state_nx = ST_MC;
                        cnt_load = 1'b1;
                    end
                end
                ST_MC: begin
                    if (cnt_zero) begin
                        state_nx = ST_IDLE;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                default: begin
                    state_nx = ST_IDLE;
                    cnt_clr  = 1'b1;
                end
            endcase
        end
    end

    // Output decode in priority order: reset, exception, MEM, multi-cycle, EX/ID.
    always_comb begin
        stall   = STALL_NONE;
        flush   = 1'b0;
        new_pc  = 32'h0;
        mc_busy = 1'b0;
        mc_done = 1'b0;
        if (rst) begin
            stall = STALL_NONE;
        end else if (exc_hit) begin
            flush  = 1'b1;
            new_pc = (excepttype == ERET_CODE) ? cp0_epc : EXC_ENTRY;
        end else if (stallreq_mem) begin
            stall   = STALL_MEM;
            mc_busy = (state == ST_MC);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mc_req) begin
                        stall = STALL_EX;
                    end else begin
                        stall   = req_stall(stallreq_ex, stallreq_id);
                        // A zero-length op completes in its issue cycle.
                        mc_done = mc_start;
                    end
                end
                ST_MC: begin
                    mc_busy = 1'b1;
                    if (cnt_zero) begin
                        mc_done = 1'b1;
                        stall   = req_stall(stallreq_ex, stallreq_id);
                    end else begin
                        stall = STALL_EX;
                    end
                end
                default: begin
                    stall = STALL_NONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: a cycle model of the controller's
// rules compared every cycle, plus directed vectors with literal expectations.
module tb_pipe_stall_ctrl;

    logic        clk;
    logic        rst;
    logic        stallreq_id;
    logic        stallreq_ex;
    logic        stallreq_mem;
    logic        mc_start;
    logic [5:0]  mc_cycles;
    logic [31:0] excepttype;
    logic [31:0] cp0_epc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        mc_busy;
    logic        mc_done;

    int checks = 0;
    int errors = 0;

    logic [5:0] exp_q[$];

    pipe_stall_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_id  (stallreq_id),
        .stallreq_ex  (stallreq_ex),
        .stallreq_mem (stallreq_mem),
        .mc_start     (mc_start),
        .mc_cycles    (mc_cycles),
        .excepttype   (excepttype),
        .cp0_epc      (cp0_epc),
        .stall        (stall),
        .flush        (flush),
        .new_pc       (new_pc),
        .mc_busy      (mc_busy),
        .mc_done      (mc_done)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Comparison helper shared by the model compare and directed checks
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stallreq_id  = 1'b0;
        stallreq_ex  = 1'b0;
        stallreq_mem = 1'b0;
        mc_start     = 1'b0;
        mc_cycles    = 6'd0;
        excepttype   = 32'h0;
        cp0_epc      = 32'h0;
    endtask

    // Model: m_left = EX cycles still ahead for the current op, counting
    // its result cycle; 0 means no op in flight.
    int m_left = 0;
    int m_nx   = 0;

    always @(negedge clk) begin
        logic [5:0]  e_stall;
        logic [5:0]  e_req;
        logic        e_flush;
        logic [31:0] e_pc;
        logic        e_busy;
        logic        e_done;
        int          nx;
        e_stall = 6'b0;
        e_flush = 1'b0;
        e_pc    = 32'h0;
        e_busy  = 1'b0;
        e_done  = 1'b0;
        nx      = m_left;
        e_req   = stallreq_ex ? 6'b001111 : (stallreq_id ? 6'b000111 : 6'b000000);
        if (rst) begin
            nx = 0;
        end else if (excepttype != 0) begin
            e_flush = 1'b1;
            e_pc    = (excepttype == 32'he) ? cp0_epc : 32'h20;
            nx      = 0;
        end else if (stallreq_mem) begin
            e_stall = 6'b011111;
            e_busy  = (m_left > 0);
        end else if (m_left > 1) begin
            e_stall = 6'b001111;
            e_busy  = 1'b1;
            nx      = m_left - 1;
        end else if (m_left == 1) begin
            e_stall = e_req;
            e_busy  = 1'b1;
            e_done  = 1'b1;
            nx      = 0;
        end else if (mc_start && mc_cycles != 0) begin
            e_stall = 6'b001111;
            nx      = int'(mc_cycles);
        end else begin
            e_stall = e_req;
            e_done  = mc_start;
        end
        chk("model_stall", 32'(stall), 32'(e_stall));
        chk("model_flush", 32'(flush), 32'(e_flush));
        chk("model_new_pc", new_pc, e_pc);
        chk("model_mc_busy", 32'(mc_busy), 32'(e_busy));
        chk("model_mc_done", 32'(mc_done), 32'(e_done));
        m_nx = nx;
    end

    always @(posedge clk) m_left = m_nx;

    // Protocol: EX must not issue a new op while one is in flight
    always @(negedge clk) begin
        if (!rst) begin
            assert (!(mc_busy && mc_start))
            else $error("mc_start issued while mc_busy");
        end
    end

    // Directed stimulus with literal expectations
    initial begin
        // 1: reset with everything asserted forces all outputs low
        rst          = 1'b1;
        stallreq_id  = 1'b1;
        stallreq_ex  = 1'b1;
        stallreq_mem = 1'b1;
        mc_start     = 1'b1;
        mc_cycles    = 6'd3;
        excepttype   = 32'h1;
        cp0_epc      = 32'h1234_5678;
        repeat (3) begin
            @(negedge clk);
            chk("rst_stall", 32'(stall), 32'h0);
            chk("rst_flush", 32'(flush), 32'h0);
            chk("rst_new_pc", new_pc, 32'h0);
            chk("rst_done", 32'(mc_done), 32'h0);
        end
        step();
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        chk("idle_stall", 32'(stall), 32'h0);

        // 2: ID, then EX, then MEM hold requests stack up
        step();
        stallreq_id = 1'b1;
        @(negedge clk);
        chk("id_stall", 32'(stall), 32'b000111);
        step();
        stallreq_ex = 1'b1;
        @(negedge clk);
        chk("ex_stall", 32'(stall), 32'b001111);
        step();
        stallreq_mem = 1'b1;
        @(negedge clk);
        chk("mem_stall", 32'(stall), 32'b011111);
        step();
        idle_inputs();

        // 3: three-cycle op, then zero-length op
        mc_start  = 1'b1;
        mc_cycles = 6'd3;
        @(negedge clk);
        chk("mc3_start_stall", 32'(stall), 32'b001111);
        chk("mc3_start_done", 32'(mc_done), 32'h0);
        step();
        mc_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("mc3_hold_stall", 32'(stall), 32'b001111);
            chk("mc3_hold_busy", 32'(mc_busy), 32'h1);
            step();
        end
        @(negedge clk);
        chk("mc3_done_stall", 32'(stall), 32'h0);
        chk("mc3_done", 32'(mc_done), 32'h1);
        step();
        @(negedge clk);
        chk("mc3_after_busy", 32'(mc_busy), 32'h0);
        chk("mc3_after_done", 32'(mc_done), 32'h0);
        mc_start  = 1'b1;
        mc_cycles = 6'd0;
        @(negedge clk);
        chk("mc0_done", 32'(mc_done), 32'h1);
        chk("mc0_stall", 32'(stall), 32'h0);
        step();
        idle_inputs();

        // 4: five-cycle op with MEM stall on cycles 3-4, done on cycle 8
        exp_q = '{6'b001111, 6'b001111, 6'b011111, 6'b011111,
                  6'b001111, 6'b001111, 6'b001111, 6'b000000};
        for (int c = 1; c <= 8; c++) begin
            logic [5:0] e;
            mc_start     = (c == 1);
            mc_cycles    = (c == 1) ? 6'd5 : 6'd0;
            stallreq_mem = (c == 3 || c == 4);
            e = exp_q.pop_front();
            @(negedge clk);
            chk("mc5_stall", 32'(stall), 32'(e));
            chk("mc5_done", 32'(mc_done), (c == 8) ? 32'h1 : 32'h0);
            step();
        end
        idle_inputs();
        @(negedge clk);
        chk("mc5_after_busy", 32'(mc_busy), 32'h0);

        // 5: exception aborts an op; ERET redirects to EPC
        step();
        mc_start  = 1'b1;
        mc_cycles = 6'd4;
        step();
        mc_start   = 1'b0;
        mc_cycles  = 6'd0;
        excepttype = 32'h1;
        @(negedge clk);
        chk("exc_flush", 32'(flush), 32'h1);
        chk("exc_new_pc", new_pc, 32'h20);
        chk("exc_stall", 32'(stall), 32'h0);
        chk("exc_done", 32'(mc_done), 32'h0);
        step();
        excepttype = 32'h0;
        repeat (5) begin
            @(negedge clk);
            chk("exc_no_done", 32'(mc_done), 32'h0);
            chk("exc_no_busy", 32'(mc_busy), 32'h0);
            step();
        end
        excepttype = 32'he;
        cp0_epc    = 32'h8000_0100;
        @(negedge clk);
        chk("eret_flush", 32'(flush), 32'h1);
        chk("eret_new_pc", new_pc, 32'h8000_0100);
        step();
        idle_inputs();

        // 6: reset mid-op drops the op with no completion pulse
        mc_start  = 1'b1;
        mc_cycles = 6'd4;
        step();
        mc_start  = 1'b0;
        mc_cycles = 6'd0;
        @(negedge clk);
        chk("rstmc_busy_before", 32'(mc_busy), 32'h1);
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("rstmc_stall", 32'(stall), 32'h0);
        step();
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("rstmc_no_busy", 32'(mc_busy), 32'h0);
            chk("rstmc_no_done", 32'(mc_done), 32'h0);
            step();
        end

        // Final report
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
